// File: rtl/fpga_spi_boot_loader.sv
// SPI master that reads a sync/length-headed bitstream from flash and streams
// 32-bit configuration words to the fabric over a valid/ready handshake.
module fpga_spi_boot_loader #(
  parameter logic [23:0] FLASH_ADDR = 24'h100000,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned MAX_WORDS  = 65536,
  parameter logic [31:0] SYNC_WORD  = 32'hFAB0_FAB1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fpga_mode_i,
  output logic        fpga_sclk_o,
  output logic        fpga_sclk_oe_o,
  output logic        fpga_cs_n_o,
  output logic        fpga_cs_n_oe_o,
  output logic        fpga_mosi_o,
  output logic        fpga_mosi_oe_o,
  input  logic        fpga_miso_i,
  output logic        fpga_miso_oe_o,
  output logic        config_busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [31:0] cfg_data_o,
  output logic        cfg_valid_o,
  input  logic        cfg_ready_i
);

  localparam logic [31:0] CMD_WORD = {8'h03, FLASH_ADDR};
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [31:0] MAX_N    = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_SYNC, S_LEN, S_DATA, S_DONE, S_ERROR
  } state_t;

  state_t      r_state;
  logic        r_mode_meta, r_mode_sync;
  logic [15:0] r_div;
  logic [4:0]  r_bit;
  logic        r_sclk, r_cs_n, r_oe;
  logic [31:0] r_mosi_sr, r_shift, r_rcv_left;
  logic        r_word_done, r_pending, r_last;
  logic        r_busy, r_done, r_error;
  logic [31:0] r_cfg_data;
  logic        r_cfg_valid;

  logic w_tick, w_hold, w_run, w_rise, w_fall, w_accept, w_fault, w_finish;

  // A held word (or the end of the payload) freezes SCLK in its low phase.
  assign w_hold   = r_pending | r_last;
  assign w_tick   = (r_div == DIV_LAST);
  assign w_run    = r_busy && !(w_hold && !r_sclk);
  assign w_rise   = w_run && w_tick && !r_sclk;
  assign w_fall   = w_run && w_tick && r_sclk;
  assign w_accept = r_cfg_valid && cfg_ready_i;
  assign w_fault  = r_word_done &&
                    (((r_state == S_SYNC) && (r_shift != SYNC_WORD)) ||
                     ((r_state == S_LEN) && ((r_shift == 32'd0) || (r_shift > MAX_N))));
  assign w_finish = (r_state == S_DATA) && r_last && !r_pending && !r_word_done && w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_meta <= 1'b0;
      r_mode_sync <= 1'b0;
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_bit       <= '0;
      r_sclk      <= 1'b0;
      r_cs_n      <= 1'b1;
      r_oe        <= 1'b0;
      r_mosi_sr   <= '0;
      r_shift     <= '0;
      r_rcv_left  <= '0;
      r_word_done <= 1'b0;
      r_pending   <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cfg_data  <= '0;
      r_cfg_valid <= 1'b0;
    end else begin
      r_mode_meta <= fpga_mode_i;
      r_mode_sync <= r_mode_meta;
      r_word_done <= 1'b0;
      if (w_run) r_div <= w_tick ? 16'd0 : r_div + 16'd1;
      if (w_rise) begin
        r_sclk      <= 1'b1;
        r_shift     <= {r_shift[30:0], fpga_miso_i};
        r_word_done <= (r_bit == 5'd31);
      end
      if (w_fall) begin
        r_sclk    <= 1'b0;
        r_bit     <= r_bit + 5'd1;
        r_mosi_sr <= {r_mosi_sr[30:0], 1'b0};
      end
      if (w_accept) r_cfg_valid <= 1'b0;

      case (r_state)
        S_IDLE: if (r_mode_sync) begin
          r_state   <= S_CMD;
          r_cs_n    <= 1'b0;
          r_oe      <= 1'b1;
          r_busy    <= 1'b1;
          r_div     <= '0;
          r_bit     <= '0;
          r_mosi_sr <= CMD_WORD;
        end
        S_CMD:  if (r_word_done) r_state <= S_SYNC;
        S_SYNC: if (r_word_done) r_state <= S_LEN;
        S_LEN:  if (r_word_done) begin
          r_state    <= S_DATA;
          r_rcv_left <= r_shift;
        end
        S_DATA: begin
          if (r_word_done) begin
            r_rcv_left <= r_rcv_left - 32'd1;
            if (r_rcv_left == 32'd1) r_last <= 1'b1;
            if (!r_cfg_valid || cfg_ready_i) begin
              r_cfg_data  <= r_shift;
              r_cfg_valid <= 1'b1;
            end else begin
              r_pending <= 1'b1;
            end
          end else if (r_pending && w_accept) begin
            r_cfg_data  <= r_shift;
            r_cfg_valid <= 1'b1;
            r_pending   <= 1'b0;
          end
        end
        default: ;
      endcase

      if (w_fault || w_finish) begin
        r_state   <= w_fault ? S_ERROR : S_DONE;
        r_cs_n    <= 1'b1;
        r_oe      <= 1'b0;
        r_busy    <= 1'b0;
        r_sclk    <= 1'b0;
        r_mosi_sr <= '0;
        if (w_fault)  r_error <= 1'b1;
        if (w_finish) r_done  <= 1'b1;
      end
    end
  end

  assign fpga_sclk_o    = r_sclk;
  assign fpga_sclk_oe_o = r_oe;
  assign fpga_cs_n_o    = r_cs_n;
  assign fpga_cs_n_oe_o = r_oe;
  assign fpga_mosi_o    = r_mosi_sr[31];
  assign fpga_mosi_oe_o = r_oe;
  assign fpga_miso_oe_o = 1'b0;
  assign config_busy_o  = r_busy;
  assign done_o         = r_done;
  assign error_o        = r_error;
  assign cfg_data_o     = r_cfg_data;
  assign cfg_valid_o    = r_cfg_valid;

endmodule
